// File: rtl/fp32_uart_word_packer.sv
// Byte-to-word packer between the UART receiver and the fp32 datapath.
// Collects NUM_BYTES bytes little-endian into one word and offers it on a
// valid/ready handshake. An inter-byte timeout drops a partial word.
module fp32_uart_word_packer #(
    parameter int unsigned NUM_BYTES    = 12,
    parameter int unsigned TIMEOUT_CLKS = 104160
) (
    input  logic                     CLK_I,
    input  logic                     RST_I,
    input  logic                     BYTE_VALID_I,
    input  logic [7:0]               BYTE_DATA_I,
    input  logic                     WORD_READY_I,
    output logic                     WORD_VALID_O,
    output logic [8*NUM_BYTES-1:0]   WORD_DATA_O,
    output logic [3:0]               BYTE_CNT_O,
    output logic                     TIMEOUT_O,
    output logic                     OVERRUN_O
);

    localparam int unsigned WORD_W = 8 * NUM_BYTES;
    localparam int unsigned TCNT_W = $clog2(TIMEOUT_CLKS);
    localparam logic [3:0]        LAST_SLOT = 4'(NUM_BYTES - 1);
    localparam logic [TCNT_W-1:0] TCNT_MAX  = TCNT_W'(TIMEOUT_CLKS - 1);

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_t;

    state_t              state;
    state_t              state_n;
    logic [TCNT_W-1:0]   tcnt;
    logic [TCNT_W-1:0]   tcnt_n;
    logic [WORD_W-1:0]   data_n;
    logic [3:0]          cnt_n;
    logic                valid_n;
    logic                timeout_n;
    logic                overrun_n;

    // State and all registered outputs.
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            state        <= COLLECT;
            tcnt         <= '0;
            WORD_DATA_O  <= '0;
            BYTE_CNT_O   <= '0;
            WORD_VALID_O <= 1'b0;
            TIMEOUT_O    <= 1'b0;
            OVERRUN_O    <= 1'b0;
        end else begin
            state        <= state_n;
            tcnt         <= tcnt_n;
            WORD_DATA_O  <= data_n;
            BYTE_CNT_O   <= cnt_n;
            WORD_VALID_O <= valid_n;
            TIMEOUT_O    <= timeout_n;
            OVERRUN_O    <= overrun_n;
        end
    end

    // Next-state, byte placement, timeout and overrun decisions.
    always_comb begin
        state_n   = state;
        tcnt_n    = tcnt;
        data_n    = WORD_DATA_O;
        cnt_n     = BYTE_CNT_O;
        valid_n   = WORD_VALID_O;
        timeout_n = 1'b0;
        overrun_n = 1'b0;

        case (state)
            COLLECT: begin
                if (BYTE_VALID_I) begin
                    for (int unsigned k = 0; k < NUM_BYTES; k++) begin
                        if (BYTE_CNT_O == 4'(k)) begin
                            data_n[8*k +: 8] = BYTE_DATA_I;
                        end
                    end
                    tcnt_n = '0;
                    if (BYTE_CNT_O == LAST_SLOT) begin
                        cnt_n   = 4'd0;
                        valid_n = 1'b1;
                        state_n = HOLD;
                    end else begin
                        cnt_n = BYTE_CNT_O + 4'd1;
                    end
                end else if (BYTE_CNT_O != 4'd0) begin
                    // Stalled partial word: count idle cycles, drop it on expiry.
                    if (tcnt == TCNT_MAX) begin
                        cnt_n     = 4'd0;
                        tcnt_n    = '0;
                        timeout_n = 1'b1;
                    end else begin
                        tcnt_n = tcnt + TCNT_W'(1);
                    end
                end
            end

            HOLD: begin
                tcnt_n = '0;
                if (WORD_READY_I) begin
                    valid_n = 1'b0;
                    state_n = COLLECT;
                    // A byte arriving with the accept starts the next word.
                    if (BYTE_VALID_I) begin
                        data_n[7:0] = BYTE_DATA_I;
                        cnt_n       = 4'd1;
                    end
                end else if (BYTE_VALID_I) begin
                    overrun_n = 1'b1;
                end
            end

            default: begin
                state_n = COLLECT;
            end
        endcase
    end

endmodule

// File: tb/tb_fp32_uart_word_packer.sv
// Bench for fp32_uart_word_packer: two instances (12-byte and 4-byte words)
// share one input stream and are checked every cycle against a word-level model.
module tb_fp32_uart_word_packer;

    localparam int unsigned NB_A = 12;
    localparam int unsigned TO_A = 20;
    localparam int unsigned NB_B = 4;
    localparam int unsigned TO_B = 6;

    logic        clk = 1'b0;
    logic        rst;
    logic        bv;
    logic [7:0]  bd;
    logic        rdy;
    logic        va, vb, toa, tob, ova, ovb;
    logic [95:0] da;
    logic [31:0] db;
    logic [3:0]  ca, cb;

    int total = 0;
    int bad   = 0;

    // Reference model state, one entry per instance.
    logic [127:0] m_data [2];
    int           m_n    [2];
    int           m_idle [2];
    logic         m_v    [2];
    logic         m_tp   [2];
    logic         m_op   [2];

    always #5 clk = ~clk;

    fp32_uart_word_packer #(.NUM_BYTES(NB_A), .TIMEOUT_CLKS(TO_A)) dut_a (
        .CLK_I(clk), .RST_I(rst), .BYTE_VALID_I(bv), .BYTE_DATA_I(bd),
        .WORD_READY_I(rdy), .WORD_VALID_O(va), .WORD_DATA_O(da),
        .BYTE_CNT_O(ca), .TIMEOUT_O(toa), .OVERRUN_O(ova)
    );

    fp32_uart_word_packer #(.NUM_BYTES(NB_B), .TIMEOUT_CLKS(TO_B)) dut_b (
        .CLK_I(clk), .RST_I(rst), .BYTE_VALID_I(bv), .BYTE_DATA_I(bd),
        .WORD_READY_I(rdy), .WORD_VALID_O(vb), .WORD_DATA_O(db),
        .BYTE_CNT_O(cb), .TIMEOUT_O(tob), .OVERRUN_O(ovb)
    );

    typedef struct {
        logic        v;
        logic [7:0]  d;
        logic        r;
        logic        ev;
        logic [3:0]  ec;
        logic        eov;
        logic [31:0] ed;
    } vec_t;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_data[i] = '0;
            m_n[i]    = 0;
            m_idle[i] = 0;
            m_v[i]    = 1'b0;
            m_tp[i]   = 1'b0;
            m_op[i]   = 1'b0;
        end
    endtask

    // Advance the model by one clock given the inputs seen at that edge.
    task automatic model_step(input logic v, input logic [7:0] d, input logic r);
        int nb;
        int lim;
        for (int i = 0; i < 2; i++) begin
            nb  = (i == 0) ? NB_A : NB_B;
            lim = (i == 0) ? TO_A : TO_B;
            m_tp[i] = 1'b0;
            m_op[i] = 1'b0;
            if (m_v[i]) begin
                m_idle[i] = 0;
                if (r) begin
                    m_v[i] = 1'b0;
                    if (v) begin
                        m_data[i][7:0] = d;
                        m_n[i] = 1;
                    end
                end else if (v) begin
                    m_op[i] = 1'b1;
                end
            end else if (v) begin
                m_data[i][8*m_n[i] +: 8] = d;
                m_n[i]    = m_n[i] + 1;
                m_idle[i] = 0;
                if (m_n[i] == nb) begin
                    m_n[i] = 0;
                    m_v[i] = 1'b1;
                end
            end else if (m_n[i] != 0) begin
                if (m_idle[i] == lim - 1) begin
                    m_n[i]    = 0;
                    m_idle[i] = 0;
                    m_tp[i]   = 1'b1;
                end else begin
                    m_idle[i] = m_idle[i] + 1;
                end
            end
        end
    endtask

    task automatic check_all();
        chk("a_valid",   128'(va),  128'(m_v[0]));
        chk("a_cnt",     128'(ca),  128'(m_n[0]));
        chk("a_timeout", 128'(toa), 128'(m_tp[0]));
        chk("a_overrun", 128'(ova), 128'(m_op[0]));
        if (m_v[0]) chk("a_data", 128'(da), m_data[0] & 128'({96{1'b1}}));
        chk("b_valid",   128'(vb),  128'(m_v[1]));
        chk("b_cnt",     128'(cb),  128'(m_n[1]));
        chk("b_timeout", 128'(tob), 128'(m_tp[1]));
        chk("b_overrun", 128'(ovb), 128'(m_op[1]));
        if (m_v[1]) chk("b_data", 128'(db), m_data[1] & 128'({32{1'b1}}));
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_a_valid"}, 128'(va), 128'(0));
        chk({tag, "_a_data"},  128'(da), 128'(0));
        chk({tag, "_a_cnt"},   128'(ca), 128'(0));
        chk({tag, "_a_pulse"}, 128'({toa, ova}), 128'(0));
        chk({tag, "_b_valid"}, 128'(vb), 128'(0));
        chk({tag, "_b_data"},  128'(db), 128'(0));
        chk({tag, "_b_cnt"},   128'(cb), 128'(0));
        chk({tag, "_b_pulse"}, 128'({tob, ovb}), 128'(0));
    endtask

    // Drive one cycle of inputs, clock, then compare both instances.
    task automatic step(input logic v, input logic [7:0] d, input logic r);
        bv  = v;
        bd  = d;
        rdy = r;
        @(posedge clk);
        model_step(v, d, r);
        #1;
        check_all();
    endtask

    // Asynchronous reset applied between clock edges.
    task automatic do_reset(input string tag);
        bv = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check_zero({tag, "_async"});
        model_reset();
        @(posedge clk);
        #1;
        check_zero({tag, "_held"});
        rst = 1'b0;
    endtask

    vec_t tbl [9];
    int   pulses;
    int   vcycles;

    initial begin
        rst = 1'b1;
        bv  = 1'b0;
        bd  = 8'h00;
        rdy = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        check_zero("reset");
        rst = 1'b0;

        // 4-byte instance: fill, overrun twice, then accept with a coincident byte.
        tbl[0] = '{1'b1, 8'h11, 1'b0, 1'b0, 4'd1, 1'b0, 32'h0};
        tbl[1] = '{1'b1, 8'h22, 1'b0, 1'b0, 4'd2, 1'b0, 32'h0};
        tbl[2] = '{1'b1, 8'h33, 1'b0, 1'b0, 4'd3, 1'b0, 32'h0};
        tbl[3] = '{1'b1, 8'h44, 1'b0, 1'b1, 4'd0, 1'b0, 32'h44332211};
        tbl[4] = '{1'b1, 8'h55, 1'b0, 1'b1, 4'd0, 1'b1, 32'h44332211};
        tbl[5] = '{1'b0, 8'h00, 1'b0, 1'b1, 4'd0, 1'b0, 32'h44332211};
        tbl[6] = '{1'b1, 8'h66, 1'b0, 1'b1, 4'd0, 1'b1, 32'h44332211};
        tbl[7] = '{1'b1, 8'hAA, 1'b1, 1'b0, 4'd1, 1'b0, 32'h0};
        tbl[8] = '{1'b0, 8'h00, 1'b0, 1'b0, 4'd1, 1'b0, 32'h0};
        for (int i = 0; i < 9; i++) begin
            step(tbl[i].v, tbl[i].d, tbl[i].r);
            chk($sformatf("tbl%0d_valid", i), 128'(vb), 128'(tbl[i].ev));
            chk($sformatf("tbl%0d_cnt", i), 128'(cb), 128'(tbl[i].ec));
            chk($sformatf("tbl%0d_ovr", i), 128'(ovb), 128'(tbl[i].eov));
            if (tbl[i].ev) chk($sformatf("tbl%0d_data", i), 128'(db), 128'(tbl[i].ed));
        end
        chk("t4_slot0", 128'(db[7:0]), 128'(8'hAA));

        // Reset mid-word with seven bytes collected.
        do_reset("t5a");
        for (int i = 0; i < 7; i++) step(1'b1, 8'(8'h30 + i), 1'b0);
        chk("t5_cnt7", 128'(ca), 128'(7));
        do_reset("t5b");

        // Full word held with ready low, then two overrun bytes.
        for (int i = 0; i < 12; i++) step(1'b1, 8'(8'hC0 + i), 1'b0);
        chk("t3_valid", 128'(va), 128'(1));
        pulses = 0;
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 8'hEE, 1'b0);
            if (ova) pulses++;
            step(1'b0, 8'h00, 1'b0);
        end
        chk("t3_overruns", 128'(pulses), 128'(2));
        chk("t3_data", 128'(da), 128'(96'hCBCAC9C8_C7C6C5C4_C3C2C1C0));
        chk("t3_cnt", 128'(ca), 128'(0));
        // Reset while holding a word.
        do_reset("t5c");
        step(1'b0, 8'h00, 1'b0);
        check_zero("t5_after");

        // Twelve back-to-back bytes with ready high.
        vcycles = 0;
        for (int i = 0; i < 12; i++) begin
            step(1'b1, 8'(i), 1'b1);
            if (va) vcycles++;
        end
        chk("t1_data", 128'(da), 128'(96'h0B0A0908_07060504_03020100));
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 8'h00, 1'b1);
            if (va) vcycles++;
        end
        chk("t1_valid_cycles", 128'(vcycles), 128'(1));
        chk("t1_cnt", 128'(ca), 128'(0));

        // Five bytes then silence until the timeout drops them.
        do_reset("t2");
        for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h50 + i), 1'b1);
        pulses = 0;
        for (int i = 1; i <= int'(TO_A); i++) begin
            step(1'b0, 8'h00, 1'b1);
            if (toa) pulses++;
            if (i == int'(TO_A) - 1) chk("t2_early", 128'(toa), 128'(0));
        end
        chk("t2_on_time", 128'(toa), 128'(1));
        chk("t2_pulses", 128'(pulses), 128'(1));
        chk("t2_cnt", 128'(ca), 128'(0));
        step(1'b0, 8'h00, 1'b1);
        chk("t2_single", 128'(toa), 128'(0));
        for (int i = 0; i < 12; i++) step(1'b1, 8'(8'h70 + i), 1'b0);
        chk("t2_clean", 128'(da), 128'(96'h7B7A7978_77767574_73727170));
        step(1'b0, 8'h00, 1'b1);

        // Randomized traffic in three moods: mixed, sparse (timeouts), saturated.
        for (int it = 0; it < 3000; it++) begin
            case ((it / 300) % 3)
                0:       step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 2) == 0));
                1:       step(1'($urandom_range(0, 15) == 0), 8'($urandom), 1'($urandom_range(0, 1)));
                default: step(1'b1, 8'($urandom), 1'($urandom_range(0, 1)));
            endcase
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
